tlb_ptw: RTL

Page-table walker that services TLB misses. It accepts a miss virtual address, walks a two-level Sv32-style page table in memory through a single-outstanding read port, and then does one of two things. On success it drives a one-cycle refill write (`refill_we` / `refill_vaddr` / `refill_paddr`) that connects directly to the TLB maintenance write port. On failure it signals a page fault. It sits between the TLB miss path and the memory/cache read port.

---
 rtl/tlb_ptw.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/tlb_ptw.sv
`default_nettype none
// ============================================================================
// Module   : tlb_ptw
// Purpose  : Two-level Sv32-style page-table walker that refills the TLB.
// Revision : 1.0
// ============================================================================
module tlb_ptw (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] satp_ppn,
  input  logic        miss_valid,
  input  logic [31:0] miss_vaddr,
  output logic        miss_ready,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        refill_we,
  output logic [31:0] refill_vaddr,
  output logic [31:0] refill_paddr,
  output logic        fault,
  output logic [31:0] fault_vaddr,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_L1_REQ  = 3'd1,
    S_L1_WAIT = 3'd2,
    S_L0_REQ  = 3'd3,
    S_L0_WAIT = 3'd4,
    S_REFILL  = 3'd5,
    S_FAULT   = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_abort;
  logic        w_abort_next;
  logic [31:0] r_vaddr;
  logic [19:0] r_table_ppn;
  logic [19:0] r_leaf_ppn;

  logic w_pte_v;
  logic w_pte_r;
  logic w_pte_w;
  logic w_pte_x;
  logic w_pte_bad;
  logic w_pte_leaf;
  logic w_unused_pte;

  assign w_pte_v      = mem_rdata[0];
  assign w_pte_r      = mem_rdata[1];
  assign w_pte_w      = mem_rdata[2];
  assign w_pte_x      = mem_rdata[3];
  assign w_pte_bad    = !w_pte_v || (w_pte_w && !w_pte_r);
  assign w_pte_leaf   = w_pte_r || w_pte_x;
  assign w_unused_pte = ^{mem_rdata[31:30], mem_rdata[9:4]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_abort <= w_abort_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_abort_next = r_abort;
    case (r_state)
      S_IDLE: begin
        if (miss_valid) begin
          w_state_next = S_L1_REQ;
          w_abort_next = 1'b0;
        end
      end
      S_L1_REQ: begin
        // Once the read is accepted its response must still be drained.
        if (mem_ready) begin
          w_state_next = S_L1_WAIT;
          w_abort_next = flush;
        end else if (flush) begin
          w_state_next = S_IDLE;
        end
      end
      S_L1_WAIT: begin
        if (mem_rvalid) begin
          w_abort_next = 1'b0;
          if (r_abort || flush)
            w_state_next = S_IDLE;
          else if (w_pte_bad)
            w_state_next = S_FAULT;
          else if (w_pte_leaf)
            w_state_next = (mem_rdata[19:10] != 10'd0) ? S_FAULT : S_REFILL;
          else
            w_state_next = S_L0_REQ;
        end else if (flush) begin
          w_abort_next = 1'b1;
        end
      end
      S_L0_REQ: begin
        if (mem_ready) begin
          w_state_next = S_L0_WAIT;
          w_abort_next = flush;
        end else if (flush) begin
          w_state_next = S_IDLE;
        end
      end
      S_L0_WAIT: begin
        if (mem_rvalid) begin
          w_abort_next = 1'b0;
          if (r_abort || flush)
            w_state_next = S_IDLE;
          else if (w_pte_bad || !w_pte_leaf)
            w_state_next = S_FAULT;
          else
            w_state_next = S_REFILL;
        end else if (flush) begin
          w_abort_next = 1'b1;
        end
      end
      S_REFILL: w_state_next = S_IDLE;
      S_FAULT:  w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // The level-1 response overwrites the root PPN with the level-0 table PPN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vaddr     <= 32'd0;
      r_table_ppn <= 20'd0;
      r_leaf_ppn  <= 20'd0;
    end else begin
      if (r_state == S_IDLE && miss_valid) begin
        r_vaddr     <= miss_vaddr;
        r_table_ppn <= satp_ppn;
      end
      if (r_state == S_L1_WAIT && mem_rvalid) begin
        r_table_ppn <= mem_rdata[29:10];
        r_leaf_ppn  <= {mem_rdata[29:20], r_vaddr[21:12]};
      end
      if (r_state == S_L0_WAIT && mem_rvalid)
        r_leaf_ppn <= mem_rdata[29:10];
    end
  end

  always_comb begin
    mem_addr = 32'd0;
    case (r_state)
      S_L1_REQ: mem_addr = {r_table_ppn, r_vaddr[31:22], 2'b00};
      S_L0_REQ: mem_addr = {r_table_ppn, r_vaddr[21:12], 2'b00};
      default:  mem_addr = 32'd0;
    endcase
  end

  assign miss_ready   = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign mem_req      = (r_state == S_L1_REQ) || (r_state == S_L0_REQ);
  assign refill_we    = (r_state == S_REFILL);
  assign fault        = (r_state == S_FAULT);
  assign refill_vaddr = {r_vaddr[31:12], 12'h000};
  assign refill_paddr = {r_leaf_ppn, 12'h000};
  assign fault_vaddr  = r_vaddr;

endmodule
`default_nettype wire
